// File: rtl/handshake_fork_pkg.sv
// Shared defaults for the one-to-many valid/ready fork.
package handshake_fork_pkg;

    localparam int unsigned DEFAULT_NUM_ELEM   = 4;
    localparam int unsigned DEFAULT_ELEM_WIDTH = 8;

endpackage

// File: rtl/handshake_fork.sv
// Broadcasts one valid/ready stream to NUM_ELEM independently stalling consumers.
// Define HANDSHAKE_FORK_READY_PASSTHRU_EN to allow reload in the last-accept cycle.
module handshake_fork
    import handshake_fork_pkg::*;
#(
    parameter int unsigned NUM_ELEM   = DEFAULT_NUM_ELEM,
    parameter int unsigned ELEM_WIDTH = DEFAULT_ELEM_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [ELEM_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic [ELEM_WIDTH-1:0] data_o [NUM_ELEM],
    output logic [NUM_ELEM-1:0]   data_valid_o,
    input  logic [NUM_ELEM-1:0]   data_ready_i
);

    logic [ELEM_WIDTH-1:0] buf_q;
    logic [NUM_ELEM-1:0]   pending_q;
    logic [NUM_ELEM-1:0]   pending_d;
    logic [NUM_ELEM-1:0]   out_fire_c;
    logic                  in_fire_c;
    // Registered EMPTY flag; held low in reset so ready is low while arst_i is high.
    logic                  empty_q;

    assign out_fire_c = pending_q & data_ready_i;

`ifdef HANDSHAKE_FORK_READY_PASSTHRU_EN
    logic last_accept_c;

    assign last_accept_c = (|pending_q) & ~(|(pending_q & ~data_ready_i));
    assign data_ready_o  = empty_q | last_accept_c;
`else
    assign data_ready_o  = empty_q;
`endif

    assign in_fire_c = data_valid_i & data_ready_o;

    // A new word owes delivery to every lane, overriding any same-cycle accepts.
    always_comb begin
        pending_d = pending_q & ~out_fire_c;
        if (in_fire_c) begin
            pending_d = '1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pending_q <= '0;
            buf_q     <= '0;
            empty_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            empty_q   <= ~(|pending_d);
            if (in_fire_c) begin
                buf_q <= data_i;
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_ELEM); i++) begin : g_lane
        assign data_o[i]       = buf_q;
        assign data_valid_o[i] = pending_q[i];
    end

endmodule

// File: tb/tb_handshake_fork.sv
// Directed plus random checks of handshake_fork against a per-lane delivery model.
// Build with or without HANDSHAKE_FORK_READY_PASSTHRU_EN.
module tb_handshake_fork;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic         clk_i = 1'b0;
    logic         arst_i;
    logic [W-1:0] data_i;
    logic         data_valid_i;
    logic         data_ready_o;
    logic [W-1:0] data_o [N];
    logic [N-1:0] data_valid_o;
    logic [N-1:0] data_ready_i;

    int vectors     = 0;
    int miscompares = 0;

    // Model: every accepted word in order, and how many of them each lane has taken.
    logic [W-1:0] sent [$];
    int           delivered [N];

    handshake_fork #(.NUM_ELEM(N), .ELEM_WIDTH(W)) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks outputs mid-cycle against the model, then advances one edge.
    task automatic cycle();
        logic [N-1:0] owed;
        logic         exp_ready;
        @(negedge clk_i);
        exp_ready = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            owed[i] = delivered[i] < sent.size();
`ifdef HANDSHAKE_FORK_READY_PASSTHRU_EN
            if (owed[i] && !data_ready_i[i]) exp_ready = 1'b0;
`else
            if (owed[i]) exp_ready = 1'b0;
`endif
        end
        chk("valid", 32'(data_valid_o), 32'(owed));
        chk("ready", 32'(data_ready_o), 32'(exp_ready));
        for (int i = 0; i < int'(N); i++) begin
            if (owed[i]) chk($sformatf("data%0d", i), 32'(data_o[i]), 32'(sent[delivered[i]]));
        end
        @(posedge clk_i);
        for (int i = 0; i < int'(N); i++) begin
            if (owed[i] && data_ready_i[i]) delivered[i]++;
        end
        if (data_valid_i && exp_ready) sent.push_back(data_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [N-1:0] r);
        data_valid_i = v;
        data_i       = d;
        data_ready_i = r;
        cycle();
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) delivered[i] = sent.size();
    endtask

    initial begin
        arst_i       = 1'b1;
        data_i       = '0;
        data_valid_i = 1'b0;
        data_ready_i = '0;
        for (int i = 0; i < int'(N); i++) delivered[i] = 0;

        // Reset then idle
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(data_ready_o), 32'd0);
        chk("rst_valid", 32'(data_valid_o), 32'd0);
        arst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("post_rst_ready", 32'(data_ready_o), 32'd1);
        for (int i = 0; i < int'(N); i++) chk("post_rst_data", 32'(data_o[i]), 32'd0);
        drive(1'b0, 8'h00, 4'h0);

        // All lanes ready: A5 visible for exactly one cycle
        drive(1'b1, 8'hA5, 4'hF);
        chk("a5_valid", 32'(data_valid_o), 32'hF);
        chk("a5_data", 32'(data_o[2]), 32'hA5);
`ifdef HANDSHAKE_FORK_READY_PASSTHRU_EN
        drive(1'b1, 8'h3C, 4'hF);
        chk("3c_valid", 32'(data_valid_o), 32'hF);
        chk("3c_data", 32'(data_o[0]), 32'h3C);
`endif
        drive(1'b0, 8'h00, 4'hF);
        chk("a5_drop", 32'(data_valid_o), 32'h0);

        // Lanes accept one per cycle in order 2,0,3,1
        drive(1'b1, 8'h11, 4'h0);
        chk("ord_full", 32'(data_valid_o), 32'hF);
        drive(1'b0, 8'h00, 4'b0100);
        chk("ord_l2", 32'(data_valid_o), 32'b1011);
        drive(1'b0, 8'h00, 4'b0001);
        chk("ord_l0", 32'(data_valid_o), 32'b1010);
        drive(1'b0, 8'h00, 4'b1000);
        chk("ord_l3", 32'(data_valid_o), 32'b0010);
        drive(1'b0, 8'h00, 4'b0010);
        chk("ord_l1", 32'(data_valid_o), 32'b0000);

        // Lane 3 stalls for 10 cycles while a new word waits
        drive(1'b1, 8'h11, 4'h0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'h22, 4'b0111);
            chk("hold_valid", 32'(data_valid_o), 32'b1000);
            chk("hold_data", 32'(data_o[3]), 32'h11);
        end
        drive(1'b1, 8'h22, 4'hF);
`ifdef HANDSHAKE_FORK_READY_PASSTHRU_EN
        chk("hold_reload", 32'(data_valid_o), 32'hF);
`else
        chk("hold_end", 32'(data_valid_o), 32'h0);
`endif
        drive(1'b1, 8'h22, 4'h0);
        chk("next_valid", 32'(data_valid_o), 32'hF);
        chk("next_data", 32'(data_o[1]), 32'h22);
        drive(1'b0, 8'h00, 4'hF);

        // Lane 0 ready stays high after delivery: no duplicate
        drive(1'b1, 8'h33, 4'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 8'h00, 4'b0001);
            chk("l0_once", 32'(data_valid_o), 32'b1110);
        end
        drive(1'b0, 8'h00, 4'hF);

        // Asynchronous reset with pending mask 1010
        drive(1'b1, 8'h5A, 4'h0);
        drive(1'b0, 8'h00, 4'b0101);
        chk("pre_rst_mask", 32'(data_valid_o), 32'b1010);
        data_ready_i = '0;
        arst_i = 1'b1;
        #2;
        chk("arst_valid", 32'(data_valid_o), 32'h0);
        chk("arst_ready", 32'(data_ready_o), 32'h0);
        chk("arst_data", 32'(data_o[1]), 32'h0);
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        drive(1'b1, 8'h77, 4'hF);
        chk("after_rst_valid", 32'(data_valid_o), 32'hF);
        chk("after_rst_data", 32'(data_o[3]), 32'h77);
        drive(1'b0, 8'h00, 4'hF);

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), N'($urandom));
        end
        repeat (4) drive(1'b0, 8'h00, 4'hF);
        for (int i = 0; i < int'(N); i++) chk("drained", 32'(delivered[i]), 32'(sent.size()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
